// File: rtl/reg_file_pkg.sv
// Shared constants and writeback-port bundle for the register file.
package reg_file_pkg;

    localparam int unsigned DefW = 8;   // default data width
    localparam int unsigned DefD = 4;   // default address width

    // One writeback port at the default widths.
    typedef struct packed {
        logic            en;
        logic [DefD-1:0] addr;
        logic [DefW-1:0] data;
    } wb_port_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-load scoreboard: one pending bit per register, a running count of
// pending registers, and the busy indications for both read ports.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned D       = DefD,
    parameter int unsigned ZERO_R0 = 0,
    parameter int unsigned BYPASS  = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         reserve_en_i,
    input  logic [D-1:0] reserve_addr_i,
    input  logic         wb_en_i,
    input  logic [D-1:0] wb_addr_i,
    input  logic [D-1:0] raddr_a_i,
    input  logic [D-1:0] raddr_b_i,
    output logic         busy_a_o,
    output logic         busy_b_o,
    output logic [D:0]   pend_count_o
);

    localparam int unsigned N = 2 ** D;

    logic [N-1:0] pend_q, pend_d;
    logic [D:0]   count_q, count_d;
    logic         res_eff, wb_eff, inc, dec;

    // Next pending vector and count; a same-cycle reserve wins over the clear.
    always_comb begin
        res_eff = reserve_en_i && !((ZERO_R0 != 0) && (reserve_addr_i == '0));
        wb_eff  = wb_en_i && !((ZERO_R0 != 0) && (wb_addr_i == '0));
        pend_d  = pend_q;
        if (wb_eff) pend_d[wb_addr_i] = 1'b0;
        if (res_eff) pend_d[reserve_addr_i] = 1'b1;
        inc     = res_eff && !pend_q[reserve_addr_i];
        dec     = wb_eff && pend_q[wb_addr_i] && !(res_eff && (reserve_addr_i == wb_addr_i));
        count_d = count_q + (D+1)'(inc) - (D+1)'(dec);
    end

    // Pending state register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    // A register is not busy when its load data is arriving this very cycle.
    always_comb begin
        busy_a_o = pend_q[raddr_a_i] &&
                   !((BYPASS != 0) && wb_eff && (wb_addr_i == raddr_a_i));
        busy_b_o = pend_q[raddr_b_i] &&
                   !((BYPASS != 0) && wb_eff && (wb_addr_i == raddr_b_i));
    end

    assign pend_count_o = count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file: ALU writeback on port A, load writeback on
// port B, two combinational read ports with optional write bypass.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned W       = DefW,
    parameter int unsigned D       = DefD,
    parameter int unsigned ZERO_R0 = 0,
    parameter int unsigned BYPASS  = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         WriteEnA,
    input  logic [D-1:0] WaddrA,
    input  logic [W-1:0] DataInA,
    input  logic         WriteEnB,
    input  logic [D-1:0] WaddrB,
    input  logic [W-1:0] DataInB,
    input  logic         ReserveEn,
    input  logic [D-1:0] ReserveAddr,
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrB,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    output logic         BusyA,
    output logic         BusyB,
    output logic [D:0]   PendCount,
    output logic         Conflict
);

    localparam int unsigned N = 2 ** D;

    logic [W-1:0] mem_q [N];
    logic         wr_a, wr_b, conflict_q;

    // Effective write strobes; R0 writes vanish when it is hardwired to zero.
    always_comb begin
        wr_a = WriteEnA && !((ZERO_R0 != 0) && (WaddrA == '0));
        wr_b = WriteEnB && !((ZERO_R0 != 0) && (WaddrB == '0));
    end

    // Storage; port B is written last so it wins an address collision.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            if (wr_a) mem_q[WaddrA] <= DataInA;
            if (wr_b) mem_q[WaddrB] <= DataInB;
        end
    end

    // One-cycle pulse after both ports hit the same register.
    always_ff @(posedge Clk) begin
        if (Reset) conflict_q <= 1'b0;
        else       conflict_q <= wr_a && wr_b && (WaddrA == WaddrB);
    end

    // Read port A: zero R0, then bypass (B over A), then stored value.
    always_comb begin
        DataOutA = mem_q[RaddrA];
        if ((BYPASS != 0) && wr_a && (WaddrA == RaddrA)) DataOutA = DataInA;
        if ((BYPASS != 0) && wr_b && (WaddrB == RaddrA)) DataOutA = DataInB;
        if ((ZERO_R0 != 0) && (RaddrA == '0)) DataOutA = '0;
    end

    // Read port B: same priority as port A.
    always_comb begin
        DataOutB = mem_q[RaddrB];
        if ((BYPASS != 0) && wr_a && (WaddrA == RaddrB)) DataOutB = DataInA;
        if ((BYPASS != 0) && wr_b && (WaddrB == RaddrB)) DataOutB = DataInB;
        if ((ZERO_R0 != 0) && (RaddrB == '0)) DataOutB = '0;
    end

    assign Conflict = conflict_q;

    reg_scoreboard #(
        .D       (D),
        .ZERO_R0 (ZERO_R0),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .clk_i          (Clk),
        .reset_i        (Reset),
        .reserve_en_i   (ReserveEn),
        .reserve_addr_i (ReserveAddr),
        .wb_en_i        (WriteEnB),
        .wb_addr_i      (WaddrB),
        .raddr_a_i      (RaddrA),
        .raddr_b_i      (RaddrB),
        .busy_a_o       (BusyA),
        .busy_b_o       (BusyB),
        .pend_count_o   (PendCount)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (plain, and hardwired-zero R0) share
// stimulus; expectations are queued per cycle and checked on the falling edge.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    typedef enum int {SelDa, SelDb, SelBa, SelBb, SelPc, SelCf} sel_e;

    typedef struct {
        int          cyc;
        bit          z;
        sel_e        sel;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    wb_port_t    wa, wb;
    logic        res_en;
    logic [3:0]  res_addr, ra, rb;

    logic [7:0]  da0, db0, da1, db1;
    logic        ba0, bb0, ba1, bb1, cf0, cf1;
    logic [4:0]  pc0, pc1;

    exp_t        q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_sb #(.W(8), .D(4), .ZERO_R0(0), .BYPASS(1)) dut (
        .Clk(clk), .Reset(rst),
        .WriteEnA(wa.en), .WaddrA(wa.addr), .DataInA(wa.data),
        .WriteEnB(wb.en), .WaddrB(wb.addr), .DataInB(wb.data),
        .ReserveEn(res_en), .ReserveAddr(res_addr),
        .RaddrA(ra), .RaddrB(rb),
        .DataOutA(da0), .DataOutB(db0), .BusyA(ba0), .BusyB(bb0),
        .PendCount(pc0), .Conflict(cf0)
    );

    reg_file_sb #(.W(8), .D(4), .ZERO_R0(1), .BYPASS(1)) dut_z (
        .Clk(clk), .Reset(rst),
        .WriteEnA(wa.en), .WaddrA(wa.addr), .DataInA(wa.data),
        .WriteEnB(wb.en), .WaddrB(wb.addr), .DataInB(wb.data),
        .ReserveEn(res_en), .ReserveAddr(res_addr),
        .RaddrA(ra), .RaddrB(rb),
        .DataOutA(da1), .DataOutB(db1), .BusyA(ba1), .BusyB(bb1),
        .PendCount(pc1), .Conflict(cf1)
    );

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                SelDa:   act = 32'(e.z ? da1 : da0);
                SelDb:   act = 32'(e.z ? db1 : db0);
                SelBa:   act = 32'(e.z ? ba1 : ba0);
                SelBb:   act = 32'(e.z ? bb1 : bb0);
                SelPc:   act = 32'(e.z ? pc1 : pc0);
                default: act = 32'(e.z ? cf1 : cf0);
            endcase
            n_tests++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s%s (cycle %0d): got %0h, expected %0h",
                         e.z ? "z:" : "", e.nm, e.cyc, act, e.val);
            end
        end
    end

    task automatic expect_v(input bit z, input sel_e sel, input logic [31:0] v,
                            input string nm);
        exp_t e;
        e.cyc = cyc; e.z = z; e.sel = sel; e.val = v; e.nm = nm;
        q.push_back(e);
    endtask

    // Same expectation for both instances.
    task automatic expect_2(input sel_e sel, input logic [31:0] v, input string nm);
        expect_v(1'b0, sel, v, nm);
        expect_v(1'b1, sel, v, nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa = '0; wb = '0; res_en = 1'b0; res_addr = '0;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
        wa.en = 1'b1; wa.addr = a; wa.data = d;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [7:0] d);
        wb.en = 1'b1; wb.addr = a; wb.data = d;
    endtask

    task automatic reserve(input logic [3:0] a);
        res_en = 1'b1; res_addr = a;
    endtask

    initial begin
        idle();
        ra = '0; rb = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;

        n_tests++;
        if (pc0 !== 5'd0 || pc1 !== 5'd0) begin
            n_fail++;
            $display("FAIL direct_reset_pend: got %0h/%0h, expected 0", pc0, pc1);
        end
        n_tests++;
        if (cf0 !== 1'b0 || cf1 !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_reset_conflict: got %0b/%0b, expected 0", cf0, cf1);
        end

        // 1: everything reads zero after reset
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i);
            expect_2(SelDa, 0, "reset_rd_a");
            expect_2(SelDb, 0, "reset_rd_b");
            if (i == 0) begin
                expect_2(SelPc, 0, "reset_pend");
                expect_2(SelBa, 0, "reset_busy_a");
                expect_2(SelBb, 0, "reset_busy_b");
                expect_2(SelCf, 0, "reset_conflict");
            end
            step();
        end

        // 2: port A write, bypassed then stored
        wr_a(4'd3, 8'h5A); ra = 4'd3;
        expect_2(SelDa, 8'h5A, "wr_a_bypass");
        step(); idle();
        expect_2(SelDa, 8'h5A, "wr_a_stored");
        step();

        // 3: both ports hit r7; B wins and Conflict pulses once
        wr_a(4'd7, 8'h11); wr_b(4'd7, 8'h22); ra = 4'd7;
        expect_2(SelDa, 8'h22, "conflict_bypass_b");
        expect_2(SelCf, 0, "conflict_not_yet");
        step(); idle();
        expect_2(SelDa, 8'h22, "conflict_stored_b");
        expect_2(SelCf, 1, "conflict_pulse");
        step();
        expect_2(SelCf, 0, "conflict_drop");
        step();

        // 4: reserve r5, then load return clears it
        reserve(4'd5); ra = 4'd5;
        expect_2(SelBa, 0, "reserve_busy_same_cycle");
        step(); idle();
        expect_2(SelPc, 1, "reserve_pend");
        expect_2(SelBa, 1, "reserve_busy");
        step();
        wr_b(4'd5, 8'h99);
        expect_2(SelBa, 0, "ld_ret_busy_bypass");
        expect_2(SelDa, 8'h99, "ld_ret_data_bypass");
        expect_2(SelPc, 1, "ld_ret_pend_before");
        step(); idle();
        expect_2(SelPc, 0, "ld_ret_pend_after");
        expect_2(SelBa, 0, "ld_ret_busy_after");
        step();

        // 5: reserve and B write on r2 together: bit stays set
        reserve(4'd2); wr_b(4'd2, 8'h44);
        step(); idle(); ra = 4'd2;
        expect_2(SelPc, 1, "res_wb_same_pend");
        expect_2(SelBa, 1, "res_wb_same_busy");
        expect_2(SelDa, 8'h44, "res_wb_same_data");
        step();
        // reserve r9 while r2 returns: no net count change
        reserve(4'd9); wr_b(4'd2, 8'h55);
        step(); idle(); ra = 4'd9; rb = 4'd2;
        expect_2(SelPc, 1, "res_wb_diff_pend");
        expect_2(SelBa, 1, "res_wb_diff_busy9");
        expect_2(SelBb, 0, "res_wb_diff_busy2");
        expect_2(SelDb, 8'h55, "res_wb_diff_data2");
        step();

        // 6a: R0 writes (dropped only in the zero-R0 instance)
        wr_a(4'd0, 8'hAA); ra = 4'd0;
        expect_v(1'b0, SelDa, 8'hAA, "r0_wr_bypass");
        expect_v(1'b1, SelDa, 8'h00, "r0_wr_bypass");
        step(); idle();
        expect_v(1'b0, SelDa, 8'hAA, "r0_stored");
        expect_v(1'b1, SelDa, 8'h00, "r0_stored");
        step();
        wr_a(4'd0, 8'h01); wr_b(4'd0, 8'h02);
        expect_v(1'b0, SelDa, 8'h02, "r0_conflict_bypass");
        expect_v(1'b1, SelDa, 8'h00, "r0_conflict_bypass");
        step(); idle();
        expect_v(1'b0, SelCf, 1, "r0_conflict_pulse");
        expect_v(1'b1, SelCf, 0, "r0_conflict_pulse");
        expect_v(1'b0, SelDa, 8'h02, "r0_conflict_stored");
        expect_v(1'b1, SelDa, 8'h00, "r0_conflict_stored");
        step();

        // 5b: reserve every register; count saturates at 16 (15 without R0)
        for (int i = 0; i < 16; i++) begin
            reserve(4'(i));
            step();
        end
        idle(); ra = 4'd0; rb = 4'd15;
        expect_v(1'b0, SelPc, 16, "reserve_all_pend");
        expect_v(1'b1, SelPc, 15, "reserve_all_pend");
        expect_v(1'b0, SelBa, 1, "reserve_all_busy_r0");
        expect_v(1'b1, SelBa, 0, "reserve_all_busy_r0");
        expect_2(SelBb, 1, "reserve_all_busy_r15");
        #1;
        n_tests++;
        if (pc0 !== 5'd16 || pc1 !== 5'd15) begin
            n_fail++;
            $display("FAIL direct_reserve_all_pend: got %0d/%0d, expected 16/15", pc0, pc1);
        end
        step();
        reserve(4'd4);
        step(); idle();
        expect_v(1'b0, SelPc, 16, "rereserve_no_wrap");
        expect_v(1'b1, SelPc, 15, "rereserve_no_wrap");
        wr_b(4'd15, 8'h77);
        expect_2(SelBb, 0, "r15_ret_busy_bypass");
        expect_2(SelDb, 8'h77, "r15_ret_data");
        step(); idle();
        expect_v(1'b0, SelPc, 15, "r15_ret_pend");
        expect_v(1'b1, SelPc, 14, "r15_ret_pend");
        step();

        // 6b: reset overrides same-cycle writes and reserve
        rst = 1'b1;
        wr_a(4'd1, 8'h33); wr_b(4'd1, 8'h44); reserve(4'd6);
        step();
        rst = 1'b0; idle(); ra = 4'd1; rb = 4'd6;
        expect_2(SelDa, 0, "rst_mid_rd_a");
        expect_2(SelDb, 0, "rst_mid_rd_b");
        expect_2(SelBa, 0, "rst_mid_busy_a");
        expect_2(SelBb, 0, "rst_mid_busy_b");
        expect_2(SelPc, 0, "rst_mid_pend");
        expect_2(SelCf, 0, "rst_mid_conflict");
        #1;
        n_tests++;
        if (da0 !== 8'h00 || db0 !== 8'h00 || da1 !== 8'h00 || db1 !== 8'h00) begin
            n_fail++;
            $display("FAIL direct_rst_mid_data: got %0h %0h %0h %0h", da0, db0, da1, db1);
        end
        n_tests++;
        if (ba0 !== 1'b0 || bb0 !== 1'b0 || ba1 !== 1'b0 || bb1 !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_rst_mid_busy: got %0b %0b %0b %0b", ba0, bb0, ba1, bb1);
        end
        n_tests++;
        if (pc0 !== 5'd0 || pc1 !== 5'd0 || cf0 !== 1'b0 || cf1 !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_rst_mid_regs: got %0h %0h %0b %0b", pc0, pc1, cf0, cf1);
        end
        step();
        ra = 4'd3; rb = 4'd7;
        expect_2(SelDa, 0, "rst_mid_r3");
        expect_2(SelDb, 0, "rst_mid_r7");
        step();

        repeat (2) step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_fail++;
            $display("FAIL %s unchecked: got none, expected %0h", e.nm, e.val);
        end
        if (n_tests < 12) begin
            n_fail++;
            $display("FAIL too few checks ran: %0d", n_tests);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
